// File: rtl/sap_pkg.sv
// Shared types and constants for the SAP microsequencer: opcodes, FSM states,
// control word layout and fixed T-state boundaries.
package sap_pkg;

    localparam int unsigned OPCODE_W     = 4;
    localparam int unsigned CTRL_W       = 14;
    localparam int unsigned STATE_W      = 3;
    localparam int unsigned T_FETCH_LAST = 2;
    localparam int unsigned T_EXEC_FIRST = 3;

    typedef enum logic [OPCODE_W-1:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_JMP = 4'h6,
        OP_JC  = 4'h7,
        OP_JZ  = 4'h8,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_e;

    typedef enum logic [STATE_W-1:0] {
        ST_START  = 3'd0,
        ST_FETCH  = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WAIT   = 3'd3,
        ST_HALTED = 3'd4
    } state_e;

    // MSB first: hlt is bit 13, out_load is bit 0
    typedef struct packed {
        logic hlt;
        logic pc_inc;
        logic pc_en;
        logic pc_load;
        logic mar_load;
        logic mem_en;
        logic ir_load;
        logic ir_en;
        logic a_load;
        logic a_en;
        logic b_load;
        logic adder_sub;
        logic adder_en;
        logic out_load;
    } ctrl_word_t;

endpackage

// File: rtl/sap_udecode.sv
// Combinational microcode ROM: maps sequencer state, T-state, opcode and flags
// to the control word and the end-of-instruction indication.
module sap_udecode
    import sap_pkg::*;
#(
    parameter int unsigned MAX_T = 6,
    parameter int unsigned TW    = $clog2(MAX_T)
) (
    input  logic [STATE_W-1:0]  i_state,
    input  logic [TW-1:0]       i_t_state,
    input  logic [OPCODE_W-1:0] i_opcode,
    input  logic                i_flag_z,
    input  logic                i_flag_c,
    output logic [CTRL_W-1:0]   o_ctrl,
    output logic                o_done
);

    ctrl_word_t w_cw;
    logic       w_nat_done;
    logic       w_force;
    logic       w_t3;
    logic       w_t4;
    logic       w_t5;

    assign w_t3 = (i_t_state == TW'(T_EXEC_FIRST));
    assign w_t4 = (i_t_state == TW'(T_EXEC_FIRST + 1));
    assign w_t5 = (i_t_state == TW'(T_EXEC_FIRST + 2));

    always_comb begin
        w_cw       = '0;
        w_nat_done = 1'b0;
        case (state_e'(i_state))
            ST_FETCH: begin
                if (i_t_state == TW'(0)) begin
                    w_cw.pc_en    = 1'b1;
                    w_cw.mar_load = 1'b1;
                end else if (i_t_state == TW'(1)) begin
                    w_cw.pc_inc = 1'b1;
                end else if (i_t_state == TW'(T_FETCH_LAST)) begin
                    w_cw.mem_en  = 1'b1;
                    w_cw.ir_load = 1'b1;
                end
            end
            ST_EXEC: begin
                case (opcode_e'(i_opcode))
                    OP_LDA: begin
                        if (w_t3) begin
                            w_cw.ir_en    = 1'b1;
                            w_cw.mar_load = 1'b1;
                        end
                        if (w_t4) begin
                            w_cw.mem_en = 1'b1;
                            w_cw.a_load = 1'b1;
                            w_nat_done  = 1'b1;
                        end
                    end
                    OP_ADD, OP_SUB: begin
                        if (w_t3) begin
                            w_cw.ir_en    = 1'b1;
                            w_cw.mar_load = 1'b1;
                        end
                        if (w_t4) begin
                            w_cw.mem_en    = 1'b1;
                            w_cw.b_load    = 1'b1;
                            w_cw.adder_sub = (opcode_e'(i_opcode) == OP_SUB);
                        end
                        if (w_t5) begin
                            w_cw.adder_en  = 1'b1;
                            w_cw.a_load    = 1'b1;
                            w_cw.adder_sub = (opcode_e'(i_opcode) == OP_SUB);
                            w_nat_done     = 1'b1;
                        end
                    end
                    OP_JMP, OP_JC, OP_JZ: begin
                        // JC/JZ look at the flags only here, in T3
                        if (w_t3) begin
                            if ((opcode_e'(i_opcode) == OP_JMP) ||
                                ((opcode_e'(i_opcode) == OP_JC) && i_flag_c) ||
                                ((opcode_e'(i_opcode) == OP_JZ) && i_flag_z)) begin
                                w_cw.ir_en   = 1'b1;
                                w_cw.pc_load = 1'b1;
                            end
                            w_nat_done = 1'b1;
                        end
                    end
                    OP_OUT: begin
                        if (w_t3) begin
                            w_cw.a_en     = 1'b1;
                            w_cw.out_load = 1'b1;
                            w_nat_done    = 1'b1;
                        end
                    end
                    OP_HLT: begin
                        if (w_t3) begin
                            w_cw.hlt   = 1'b1;
                            w_nat_done = 1'b1;
                        end
                    end
                    default: w_nat_done = w_t3;
                endcase
            end
            ST_HALTED: w_cw.hlt = 1'b1;
            default: ;
        endcase
        // Watchdog: the last slot always ends the instruction with no strobes
        w_force = (state_e'(i_state) == ST_EXEC) && !w_nat_done &&
                  (i_t_state >= TW'(MAX_T - 1));
        if (w_force) begin
            w_cw = '0;
        end
    end

    assign o_ctrl = w_cw;
    assign o_done = w_nat_done | w_force;

endmodule

// File: rtl/sap_ctrl_seq.sv
// SAP microsequencer: T-state counter, run/step/halt FSM and step edge detect
// around the microcode ROM; the control word follows the registered state.
module sap_ctrl_seq
    import sap_pkg::*;
#(
    parameter  int unsigned MAX_T = 6,
    localparam int unsigned TW    = $clog2(MAX_T)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic                step,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                flag_z,
    input  logic                flag_c,
    output logic [CTRL_W-1:0]   ctrl_out,
    output logic [TW-1:0]       t_state,
    output logic                halted,
    output logic                instr_done
);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [TW-1:0]     r_t;
    logic [TW-1:0]     w_t_nxt;
    logic              r_step_q;
    logic              r_halted;
    logic [CTRL_W-1:0] w_ctrl;
    logic              w_done;
    ctrl_word_t        w_cw;
    logic              w_step_rise;

    sap_udecode #(
        .MAX_T (MAX_T),
        .TW    (TW)
    ) u_udecode (
        .i_state   (r_state),
        .i_t_state (r_t),
        .i_opcode  (opcode),
        .i_flag_z  (flag_z),
        .i_flag_c  (flag_c),
        .o_ctrl    (w_ctrl),
        .o_done    (w_done)
    );

    assign w_cw        = ctrl_word_t'(w_ctrl);
    assign w_step_rise = step & ~r_step_q;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_START;
            r_t      <= '0;
            r_step_q <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_t      <= w_t_nxt;
            r_step_q <= step;
            r_halted <= (w_state_nxt == ST_HALTED);
        end
    end

    // Next-state logic; run is only consulted at instruction boundaries
    always_comb begin
        w_state_nxt = r_state;
        w_t_nxt     = '0;
        case (r_state)
            ST_START: w_state_nxt = run ? ST_FETCH : ST_WAIT;
            ST_WAIT: begin
                if (w_step_rise) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (r_t == TW'(T_FETCH_LAST)) begin
                    w_state_nxt = ST_EXEC;
                    w_t_nxt     = TW'(T_EXEC_FIRST);
                end else begin
                    w_t_nxt = r_t + TW'(1);
                end
            end
            ST_EXEC: begin
                if (w_done) begin
                    if (w_cw.hlt) begin
                        w_state_nxt = ST_HALTED;
                    end else begin
                        w_state_nxt = run ? ST_FETCH : ST_WAIT;
                    end
                end else begin
                    w_t_nxt = r_t + TW'(1);
                end
            end
            ST_HALTED: w_state_nxt = ST_HALTED;
            default:   w_state_nxt = ST_START;
        endcase
    end

    // Outputs
    always_comb begin
        ctrl_out   = w_ctrl;
        instr_done = w_done;
        t_state    = r_t;
        halted     = r_halted;
    end

endmodule
